timing_ir_unit: RTL and testbench
=================================

// Module: timing_ir_unit
// PURPOSE
//  Cycle-timing and instruction-register stage directly upstream of the instruction decoder.
//  Owns the 3-bit instruction cycle counter and the 8-bit IR; the decoder consumes cycle/IR
//  and returns I_cycle/R_cycle. Latches each new opcode from the data latch at the instruction
//  boundary, sequences CPU start-up after reset, and recovers from runaway cycle counts.
// PARAMETERS
//  RESET_CYCLES  2      clk_ph2 edges held in STARTUP after rst deasserts (1..15)
//  MAX_CYCLE     7      highest legal cycle value; I_cycle at this value is a fault
//  RESET_OPCODE  8'h00  opcode forced into IR during STARTUP and fault recovery
// PORTS
//  clk_ph2      in   1  clock, phase 2; all state updates on posedge
//  rst          in   1  synchronous, active-low reset
//  I_cycle      in   1  from decoder: increment cycle counter
//  R_cycle      in   1  from decoder: reset cycle counter, begin new instruction
//  rdy          in   1  1 = advance; 0 = freeze all state (bus wait)
//  dl_in        in   8  data latch output; carries opcode byte when R_cycle is sampled
//  cycle        out  3  current instruction cycle, to decoder
//  IR           out  8  instruction register, to decoder
//  sync         out  1  registered; 1 for the one cycle after a new opcode is loaded
//  single_byte  out  1  combinational from IR: IR[3:0]==4'h8 or IR[3:0]==4'hA
//  startup      out  1  registered; 1 while in STARTUP
//  cyc_err      out  1  sticky fault flag: I_cycle seen at cycle==MAX_CYCLE
// BEHAVIOUR
//  Reset (rst==0 at posedge): cycle=0, IR=RESET_OPCODE, sync=0, startup=1, cyc_err=0,
//   startup counter=0, state=STARTUP. Reset wins over every other input, in any state.
//  STARTUP: cycle held 0, IR held RESET_OPCODE, I_cycle/R_cycle ignored. Counter increments
//   each posedge with rdy==1; after RESET_CYCLES such edges -> RUN, startup=0 on that edge.
//   rdy==0 holds the counter.
//  RUN, per posedge, in priority order:
//   1. rdy==0: cycle, IR, cyc_err held; sync forced 0.
//   2. R_cycle==1 (regardless of I_cycle): cycle<=0, IR<=dl_in, sync<=1.
//   3. I_cycle==1 and cycle<MAX_CYCLE: cycle<=cycle+1, sync<=0.
//   4. I_cycle==1 and cycle==MAX_CYCLE: cyc_err<=1, cycle<=0, IR<=RESET_OPCODE, sync<=0
//      (no wrap to 0 with the old IR; forces decoder into its default re-fetch path).
//   5. neither: cycle and IR held, sync<=0.
//  Latency: a new opcode is visible on IR one edge after R_cycle is sampled; cycle==0 on the
//   same edge. sync is never high for two consecutive cycles unless R_cycle is asserted on
//   consecutive edges.
//  cyc_err clears only on rst. single_byte has no latency relative to IR.
//  Counter arithmetic: cycle is 3-bit unsigned; the fault rule (4) replaces natural wrap.
// TESTING
//  1. rst=0 2 edges, release, RESET_CYCLES=2 -> startup=1 for 2 edges, cycle=0,
//     IR=8'h00 throughout, then startup=0.
//  2. RUN, dl_in=8'h69, R_cycle=1 one edge -> IR=8'h69, cycle=0, sync=1 for one cycle;
//     then I_cycle=1 -> cycle=1, sync=0.
//  3. dl_in=8'h6D, R_cycle; I_cycle x3 -> cycle 1,2,3; R_cycle with dl_in=8'h38 ->
//     cycle=0, IR=8'h38, single_byte=1.
//  4. I_cycle and R_cycle both 1 at cycle=2 -> cycle=0, IR=dl_in (reset wins), sync=1.
//  5. rdy=0 for 3 edges with I_cycle=1 -> cycle/IR unchanged, sync=0; rdy=1 -> cycle+1.
//  6. Drive I_cycle 8 times from cycle=0 -> at the 8th edge cycle=0, IR=8'h00,
//     cyc_err=1 sticky; mid-instruction rst=0 -> cyc_err=0, startup=1.

Source files
------------

// File: rtl/timing_ir_unit.sv
// timing_ir_unit: cycle-timing and instruction-register stage feeding the instruction decoder.
//
// Owns the 3-bit instruction cycle counter and the 8-bit IR. The decoder consumes cycle/IR and
// returns I_cycle (advance) and R_cycle (start new instruction). After reset the unit holds
// the CPU in a start-up state for RESET_CYCLES ready edges. A runaway cycle count is treated as
// a fault: the IR is forced to RESET_OPCODE and a sticky error flag is raised.
//
// Ports:
//   clk_ph2      in   clock, phase 2; all state updates on posedge
//   rst          in   synchronous, active-low reset
//   I_cycle      in   decoder request: increment cycle counter
//   R_cycle      in   decoder request: reset cycle counter, load new opcode
//   rdy          in   1 = advance, 0 = freeze state (bus wait)
//   dl_in        in   data latch output, opcode byte when R_cycle is sampled
//   cycle        out  current instruction cycle
//   IR           out  instruction register
//   sync         out  high for the one cycle after a new opcode is loaded
//   single_byte  out  IR low nibble is 8 or A
//   startup      out  high while in the start-up state
//   cyc_err      out  sticky: I_cycle was seen with cycle at MAX_CYCLE
module timing_ir_unit #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLE    = 7,
  parameter logic [7:0]  RESET_OPCODE = 8'h00
) (
  input  logic       clk_ph2,
  input  logic       rst,
  input  logic       I_cycle,
  input  logic       R_cycle,
  input  logic       rdy,
  input  logic [7:0] dl_in,
  output logic [2:0] cycle,
  output logic [7:0] IR,
  output logic       sync,
  output logic       single_byte,
  output logic       startup,
  output logic       cyc_err
);

  localparam logic [2:0] MaxCycle    = 3'(MAX_CYCLE);
  localparam logic [3:0] StartupLast = 4'(RESET_CYCLES - 1);

  typedef enum logic [0:0] {StStartup, StRun} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] cycle_q, cycle_d;
  logic [7:0] ir_q, ir_d;
  logic       sync_q, sync_d;
  logic       startup_q, startup_d;
  logic       err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cycle_d = cycle_q;
    ir_d    = ir_q;
    sync_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      StStartup: begin
        // Decoder requests are ignored until the start-up count completes.
        cycle_d = 3'd0;
        ir_d    = RESET_OPCODE;
        if (rdy) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == StartupLast) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!rdy) begin
          // Bus wait: hold everything, sync drops.
        end else if (R_cycle) begin
          cycle_d = 3'd0;
          ir_d    = dl_in;
          sync_d  = 1'b1;
        end else if (I_cycle) begin
          if (cycle_q >= MaxCycle) begin
            // Runaway instruction: no wrap with the stale opcode; force the decoder
            // down its default re-fetch path instead.
            err_d   = 1'b1;
            cycle_d = 3'd0;
            ir_d    = RESET_OPCODE;
          end else begin
            cycle_d = cycle_q + 3'd1;
          end
        end
      end
      default: state_d = StStartup;
    endcase

    startup_d = (state_d == StStartup);
  end

  always_ff @(posedge clk_ph2) begin
    if (!rst) begin
      state_q   <= StStartup;
      cnt_q     <= 4'd0;
      cycle_q   <= 3'd0;
      ir_q      <= RESET_OPCODE;
      sync_q    <= 1'b0;
      startup_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cycle_q   <= cycle_d;
      ir_q      <= ir_d;
      sync_q    <= sync_d;
      startup_q <= startup_d;
      err_q     <= err_d;
    end
  end

  assign cycle       = cycle_q;
  assign IR          = ir_q;
  assign sync        = sync_q;
  assign startup     = startup_q;
  assign cyc_err     = err_q;
  assign single_byte = (ir_q[3:0] == 4'h8) || (ir_q[3:0] == 4'hA);

endmodule

// File: tb/tb_timing_ir_unit.sv
module tb_timing_ir_unit;

  logic       clk_ph2;
  logic       rst;
  logic       I_cycle;
  logic       R_cycle;
  logic       rdy;
  logic [7:0] dl_in;
  logic [2:0] cycle;
  logic [7:0] IR;
  logic       sync;
  logic       single_byte;
  logic       startup;
  logic       cyc_err;

  int checks = 0;
  int errors = 0;

  timing_ir_unit #(
    .RESET_CYCLES(2),
    .MAX_CYCLE   (7),
    .RESET_OPCODE(8'h00)
  ) dut (
    .clk_ph2    (clk_ph2),
    .rst        (rst),
    .I_cycle    (I_cycle),
    .R_cycle    (R_cycle),
    .rdy        (rdy),
    .dl_in      (dl_in),
    .cycle      (cycle),
    .IR         (IR),
    .sync       (sync),
    .single_byte(single_byte),
    .startup    (startup),
    .cyc_err    (cyc_err)
  );

  initial clk_ph2 = 1'b0;
  always #5 clk_ph2 = ~clk_ph2;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       ic;
    logic       rc;
    logic [7:0] dl;
    logic [2:0] e_cycle;
    logic [7:0] e_ir;
    logic       e_sync;
    logic       e_sb;
    logic       e_startup;
    logic       e_err;
  } vec_t;

  localparam int NumVec = 23;
  vec_t vecs[NumVec];

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic ic, input logic rc,
                      input logic [7:0] dl);
    @(negedge clk_ph2);
    rst     = r;
    rdy     = rd;
    I_cycle = ic;
    R_cycle = rc;
    dl_in   = dl;
    @(posedge clk_ph2);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [2:0] e_cycle, input logic [7:0] e_ir,
                           input logic e_sync, input logic e_sb, input logic e_startup,
                           input logic e_err);
    check("cycle", idx, {5'd0, cycle}, {5'd0, e_cycle});
    check("IR", idx, IR, e_ir);
    check("sync", idx, {7'd0, sync}, {7'd0, e_sync});
    check("single_byte", idx, {7'd0, single_byte}, {7'd0, e_sb});
    check("startup", idx, {7'd0, startup}, {7'd0, e_startup});
    check("cyc_err", idx, {7'd0, cyc_err}, {7'd0, e_err});
  endtask

  initial begin
    //             rst   rdy   ic    rc    dl     cyc   ir     sync  sb    st    err
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    // Start-up: requests ignored, two ready edges.
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h69, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    // First opcode and increment.
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h69, 3'd0, 8'h69, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 8'h69, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h6D, 3'd0, 8'h6D, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 8'h6D, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd2, 8'h6D, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd3, 8'h6D, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h38, 3'd0, 8'h38, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 8'h38, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd2, 8'h38, 1'b0, 1'b1, 1'b0, 1'b0};
    // I_cycle and R_cycle together: R_cycle wins. Back-to-back R_cycle keeps sync high.
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h4A, 3'd0, 8'h4A, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h4A, 3'd0, 8'h4A, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 8'h4A, 1'b0, 1'b1, 1'b0, 1'b0};
    // Bus wait freezes cycle/IR, even with R_cycle.
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 8'h4A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 8'h4A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 8'h4A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd2, 8'h4A, 1'b0, 1'b1, 1'b0, 1'b0};
    // rdy low right after a load forces sync low; idle holds.
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h0C, 3'd0, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, 3'd0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b0; rdy = 1'b1; I_cycle = 1'b0; R_cycle = 1'b0; dl_in = 8'h00;

    for (int i = 0; i < NumVec; i++) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].ic, vecs[i].rc, vecs[i].dl);
      check_all(i, vecs[i].e_cycle, vecs[i].e_ir, vecs[i].e_sync, vecs[i].e_sb,
                vecs[i].e_startup, vecs[i].e_err);
    end

    // Runaway count: load 0x6D, then 7 increments reach 7, the 8th faults.
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h6D);
    check_all(100, 3'd0, 8'h6D, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      check_all(100 + k, 3'(k), 8'h6D, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check_all(108, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Sticky across further activity.
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check_all(109, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hA8);
    check_all(110, 3'd0, 8'hA8, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check_all(111, 3'd1, 8'hA8, 1'b0, 1'b1, 1'b0, 1'b1);

    // Mid-instruction reset clears the fault and re-enters start-up.
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check_all(200, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    // rdy low holds the start-up counter.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h55);
    check_all(201, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    check_all(202, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    check_all(203, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    check_all(204, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h9A);
    check_all(205, 3'd0, 8'h9A, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
